// File: rtl/apb_regfile_slave.sv
// APB4 register-file slave: DEPTH read/write registers of DATA_W bits with
// byte-strobe writes, programmable wait states and PSLVERR on bad addresses.
module apb_regfile_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'((1 << LSB) - 1);
    // One extra bit so DEPTH == 2^(ADDR_W-LSB) still fits.
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]        WAIT_LD   = 4'(WAIT_STATES);

    // DONE is the single cycle in which PREADY is high.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t              state_q,   state_d;
    logic [3:0]          wcnt_q,    wcnt_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic                write_q,   write_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [NB-1:0]       strb_q,    strb_d;
    logic                err_q,     err_d;
    logic [DATA_W-1:0]   prdata_q,  prdata_d;
    logic                pready_q,  pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];

    logic [ADDR_W-1:0]   addr_idx;
    logic                req_err;
    logic                unused_pprot;

    // Protection attributes carry no meaning for this register bank.
    assign unused_pprot = ^PPROT;

    // Decode the live bus address: word index plus alignment/range error.
    always_comb begin
        addr_idx = PADDR >> LSB;
        req_err  = (|(PADDR & LSB_MASK)) | ({1'b0, addr_idx} >= DEPTH_LIM);
    end

    // Transfer sequencing, response generation and register write-back.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        regs_d    = regs_q;

        case (state_q)
            ST_IDLE: begin
                // An access phase without a preceding setup is ignored.
                if (PSEL && !PENABLE) begin
                    idx_d   = addr_idx[IDX_W-1:0];
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    err_d   = req_err;
                    wcnt_d  = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        // Zero-wait: respond in the very first access cycle.
                        state_d   = ST_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = req_err;
                        prdata_d  = (req_err || PWRITE) ? '0
                                                        : regs_q[addr_idx[IDX_W-1:0]];
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                if (!PSEL || !PENABLE) begin
                    // Master abandoned the transfer: no response, no write.
                    state_d = ST_IDLE;
                end else if (wcnt_q > 4'd1) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    wcnt_d    = 4'd0;
                    state_d   = ST_DONE;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    prdata_d  = (err_q || write_q) ? '0 : regs_q[idx_q];
                end
            end

            ST_DONE: begin
                // The write lands on the edge that closes the PREADY cycle.
                if (write_q && !err_q) begin
                    for (int b = 0; b < NB; b++) begin
                        if (strb_q[b]) begin
                            regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, response and register storage with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= 4'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (32-bit zero-wait, 32-bit
// two-wait, 16-bit/4-deep three-wait) driven over shared bus wires with
// per-instance PSEL, checked against an array model of the register bank.
module tb_apb_regfile_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  sel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    logic [31:0] prdata_a, prdata_b;
    logic [15:0] prdata_c;
    logic        pready_a, pready_b, pready_c;
    logic        pslverr_a, pslverr_b, pslverr_c;

    apb_regfile_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) u_a (
        .PCLK(clk), .PRESET(rst), .PSEL(sel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

    apb_regfile_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(2)) u_b (
        .PCLK(clk), .PRESET(rst), .PSEL(sel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

    apb_regfile_slave #(.ADDR_W(8), .DATA_W(16), .DEPTH(4), .WAIT_STATES(3)) u_c (
        .PCLK(clk), .PRESET(rst), .PSEL(sel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata[15:0]), .PSTRB(pstrb[1:0]), .PPROT(pprot),
        .PRDATA(prdata_c), .PREADY(pready_c), .PSLVERR(pslverr_c));

    int n_chk = 0;
    int n_err = 0;

    int cfg_nb    [3] = '{4, 4, 2};
    int cfg_depth [3] = '{16, 16, 4};
    int cfg_wait  [3] = '{0, 2, 3};

    logic [31:0] mdl [3][16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void get_out(input int d, output logic [31:0] rd,
                                    output logic rdy, output logic se);
        case (d)
            0:       begin rd = prdata_a;         rdy = pready_a; se = pslverr_a; end
            1:       begin rd = prdata_b;         rdy = pready_b; se = pslverr_b; end
            default: begin rd = {16'h0, prdata_c}; rdy = pready_c; se = pslverr_c; end
        endcase
    endfunction

    function automatic void clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++)
                mdl[d][i] = 32'h0;
    endfunction

    // One full APB transfer; entered and left at #1 after a rising edge.
    task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic se, output int lat);
        logic [31:0] r;
        logic        y, e;
        sel      = 3'b000;
        sel[d]   = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = a;
        pwdata   = wd;
        pstrb    = st;
        pprot    = 3'($urandom);
        @(posedge clk); #1;
        // Scramble the address-phase signals: the slave must ignore them now.
        penable  = 1'b1;
        paddr    = 8'($urandom);
        pwdata   = $urandom;
        pstrb    = 4'($urandom);
        pwrite   = 1'($urandom);
        lat = 1;
        get_out(d, r, y, e);
        while (!y && lat < 40) begin
            chk($sformatf("wait_prdata_d%0d", d), 64'(r), 64'h0);
            @(posedge clk); #1;
            lat++;
            get_out(d, r, y, e);
        end
        chk($sformatf("pready_seen_d%0d", d), 64'(y), 64'h1);
        rd = r;
        se = e;
        @(posedge clk); #1;
        sel     = 3'b000;
        penable = 1'b0;
        get_out(d, r, y, e);
        chk($sformatf("pready_drop_d%0d", d), 64'(y), 64'h0);
        chk($sformatf("prdata_clear_d%0d", d), 64'(r), 64'h0);
    endtask

    // Transfer plus comparison against the register-bank model.
    task automatic do_op(input int d, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rd);
        int   nb, idx, lat;
        logic err, se;
        nb  = cfg_nb[d];
        idx = int'(a) / nb;
        err = ((int'(a) % nb) != 0) || (idx >= cfg_depth[d]);
        xfer(d, wr, a, wd, st, rd, se, lat);
        chk($sformatf("latency_d%0d", d), 64'(lat), 64'(cfg_wait[d] + 1));
        chk($sformatf("slverr_d%0d_a%0h", d, a), 64'(se), 64'(err));
        if (!wr)
            chk($sformatf("rdata_d%0d_a%0h", d, a), 64'(rd), err ? 64'h0 : 64'(mdl[d][idx]));
        if (wr && !err)
            for (int b = 0; b < nb; b++)
                if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] r;
        logic        y, e;
        int          d, nb;
        logic [7:0]  a;

        rst = 1'b1; sel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'h0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            get_out(i, r, y, e);
            chk($sformatf("rst_pready_d%0d", i), 64'(y), 64'h0);
            chk($sformatf("rst_pslverr_d%0d", i), 64'(e), 64'h0);
            chk($sformatf("rst_prdata_d%0d", i), 64'(r), 64'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic write/read and the "APB" string word.
        do_op(0, 1'b1, 8'h00, 32'd17, 4'hF, rd);
        do_op(0, 1'b0, 8'h00, 32'h0, 4'h0, rd);
        chk("read0_17", 64'(rd), 64'd17);
        do_op(0, 1'b1, 8'h08, 32'h0041_5042, 4'hF, rd);
        do_op(0, 1'b0, 8'h08, 32'h0, 4'h0, rd);
        chk("read8_apb", 64'(rd), 64'h0041_5042);

        // Byte strobes.
        do_op(0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, rd);
        do_op(0, 1'b1, 8'h04, 32'h1234_5678, 4'b0101, rd);
        do_op(0, 1'b0, 8'h04, 32'h0, 4'h0, rd);
        chk("strobe_merge", 64'(rd), 64'hFF34_FF78);

        // Out-of-range read and misaligned write.
        do_op(0, 1'b0, 8'h40, 32'h0, 4'h0, rd);
        do_op(0, 1'b1, 8'h02, 32'hDEAD_BEEF, 4'hF, rd);
        do_op(0, 1'b0, 8'h00, 32'h0, 4'h0, rd);
        chk("misaligned_no_write", 64'(rd), 64'd17);

        // Two wait states.
        do_op(1, 1'b1, 8'h0C, 32'hCAFE_F00D, 4'hF, rd);
        do_op(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd);
        chk("wait2_read", 64'(rd), 64'hCAFE_F00D);

        // 16-bit, 4-deep instance.
        do_op(2, 1'b1, 8'h06, 32'h0000_A5A5, 4'h3, rd);
        do_op(2, 1'b0, 8'h06, 32'h0, 4'h0, rd);
        chk("w16_read6", 64'(rd), 64'hA5A5);
        do_op(2, 1'b0, 8'h08, 32'h0, 4'h0, rd);

        // Abort: drop PSEL during a three-wait write to address 0.
        sel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
        pwdata = 32'h0000_BEEF; pstrb = 4'h3;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        sel = 3'b000; penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_pready", 64'(pready_c), 64'h0);
            @(posedge clk); #1;
        end
        do_op(2, 1'b0, 8'h00, 32'h0, 4'h0, rd);
        chk("abort_reg0", 64'(rd), 64'h0);

        // Reset during the PREADY cycle of a zero-wait write.
        sel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
        pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("pre_rst_pready", 64'(pready_a), 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; sel = 3'b000; penable = 1'b0;
        clear_model();
        chk("midrst_pready", 64'(pready_a), 64'h0);
        chk("midrst_pslverr", 64'(pslverr_a), 64'h0);
        chk("midrst_prdata", 64'(prdata_a), 64'h0);
        do_op(0, 1'b0, 8'h00, 32'h0, 4'h0, rd);
        chk("postrst_read0", 64'(rd), 64'h0);
        do_op(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd);

        // Randomized traffic, mixed back-to-back and gapped.
        for (int n = 0; n < 300; n++) begin
            d  = $urandom_range(0, 2);
            nb = cfg_nb[d];
            if ($urandom_range(0, 3) == 0)
                a = 8'($urandom);
            else
                a = 8'($urandom_range(0, cfg_depth[d] - 1) * nb);
            do_op(d, 1'($urandom), a, $urandom, 4'($urandom), rd);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // Final sweep of every register against the model.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < cfg_depth[i]; j++)
                do_op(i, 1'b0, 8'(j * cfg_nb[i]), 32'h0, 4'h0, rd);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
